// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_XOR   = 4'h3,
    OP_SLL   = 4'h4,
    OP_SRL   = 4'h5,
    OP_SUB   = 4'h6,
    OP_SLTU  = 4'h7,
    OP_SLT   = 4'h8,
    OP_SRA   = 4'h9,
    OP_MUL   = 4'hA,
    OP_MULHU = 4'hB,
    OP_DIVU  = 4'hC,
    OP_REMU  = 4'hD,
    OP_RSV0  = 4'hE,
    OP_RSV1  = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE,
    ITER
  } state_e;

  // One bit per opcode; set for MUL/MULHU/DIVU/REMU.
  localparam logic [15:0] OP_ITER_MASK = 16'h3C00;

  function automatic logic op_is_iter(logic [3:0] op);
    return OP_ITER_MASK[op];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiplier / restoring divider sharing one 2*WIDTH accumulator.
// Fixed WIDTH-cycle latency; done and result are valid during the final step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q, sel_hi_q, active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     sum, rem_sh;
  logic [WIDTH-1:0]   rem_sub;

  // Multiply: acc = {partial, multiplier}, add-then-shift-right.
  // Divide:   acc = {remainder, quotient}, shift-left-then-trial-subtract.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, b_q}) acc_step = {rem_sub, acc_q[WIDTH-2:0], 1'b1};
      else                       acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  assign done   = active_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign result = sel_hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= {{WIDTH{1'b0}}, a};
      b_q      <= b;
      is_div_q <= op inside {OP_DIVU, OP_REMU};
      sel_hi_q <= op inside {OP_MULHU, OP_REMU};
      active_q <= 1'b1;
      cnt_q    <= '0;
    end else if (active_q) begin
      acc_q <= acc_step;
      if (done) active_q <= 1'b0;
      if (cnt_q != CNT_W'(WIDTH)) cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// WIDTH-bit ALU with valid/ready handshakes; single-cycle ops in one cycle,
// multiply/divide iterated one bit per cycle in alu_muldiv_iter.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  state_e             state_q;
  logic               out_valid_q, out_zero_q;
  logic [WIDTH-1:0]   out_result_q, single_res, iter_res;
  logic [TAG_W-1:0]   out_tag_q, tag_iter_q;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, is_iter, iter_start, iter_done;
  alu_op_e            op;

  assign op    = alu_op_e'(in_op);
  assign shamt = in_b[SHAMT_W-1:0];

  always_comb begin
    single_res = '0;
    case (op)
      OP_AND:  single_res = in_a & in_b;
      OP_OR:   single_res = in_a | in_b;
      OP_ADD:  single_res = in_a + in_b;
      OP_XOR:  single_res = in_a ^ in_b;
      OP_SLL:  single_res = in_a << shamt;
      OP_SRL:  single_res = in_a >> shamt;
      OP_SUB:  single_res = in_a - in_b;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SRA:  single_res = unsigned'($signed(in_a) >>> shamt);
      default: single_res = '0;
    endcase
  end

  assign in_ready   = !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign is_iter    = op_is_iter(in_op);
  assign iter_start = accept && is_iter;

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clock  (clock),
    .reset_n(reset_n),
    .flush  (flush),
    .start  (iter_start),
    .op     (op),
    .a      (in_a),
    .b      (in_b),
    .done   (iter_done),
    .result (iter_res)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_tag_q    <= '0;
      tag_iter_q   <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (accept && !is_iter) begin
        out_valid_q  <= 1'b1;
        out_result_q <= single_res;
        out_zero_q   <= (single_res == '0);
        out_tag_q    <= in_tag;
      end else if (iter_done) begin
        out_valid_q  <= 1'b1;
        out_result_q <= iter_res;
        out_zero_q   <= (iter_res == '0);
        out_tag_q    <= tag_iter_q;
        state_q      <= IDLE;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (iter_start) begin
        state_q    <= ITER;
        tag_iter_q <= in_tag;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_tag    = out_tag_q;
  assign busy       = (state_q == ITER);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit integer ALU with valid/ready handshakes on input and output; it succeeds the fixed 32-bit combinational ALU in the execute stage.
- Single-cycle ops produce a registered result one cycle after acceptance.
- MUL/MULHU/DIVU/REMU run iteratively, one bit per cycle, in an internal sub-unit.
- An opaque tag travels with each operation so the core can match results to issuers.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8.
TAG_W, 4, width of the tag carried alongside each operation.
SHAMT_W, $clog2(WIDTH), derived localparam (not overridable); shift-amount bits taken from in_b.

Ports:
clock  input  1  single clock, all state rising-edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous abort of in-flight op and held result.
in_valid  input  1  operation offered.
in_ready  output  1  operation accepted when in_valid && in_ready.
in_op  input  4  opcode, encodings below.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_tag  input  TAG_W  caller tag.
out_valid  output  1  result held.
out_ready  input  1  consumer takes result when out_valid && out_ready.
out_result  output  WIDTH  result.
out_zero  output  1  out_result == 0.
out_tag  output  TAG_W  tag of the op that produced the result.
busy  output  1  iterative op in progress.

Behaviour:
- Opcodes, legacy 3-bit codes preserved with in_op[3]=0:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLTU (unsigned A<B -> 1 else 0).
  - 1000 SLT (signed), 1001 SRA, 1010 MUL (low WIDTH of unsigned A*B), 1011 MULHU (high WIDTH).
  - 1100 DIVU, 1101 REMU, 1110/1111 -> result 0.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. Shifts use in_b[SHAMT_W-1:0] only; upper B bits are ignored.
- Divide by zero: DIVU -> all ones; REMU -> A. No exception is raised.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
  - ITER: in_ready = 0, busy = 1.
- Single-cycle op accepted in cycle t: out_valid=1 with result/tag at t+1. Sustained throughput is 1 op/cycle when out_ready stays high (same-cycle drain plus accept, no bubble).
- Iterative op accepted at t:
  - ITER for cycles t+1..t+WIDTH.
  - Result written and out_valid=1 at t+WIDTH+1; state returns to IDLE the same edge.
  - Operands and tag are latched at accept.
- Output register holds result/zero/tag stable while out_valid && !out_ready.
- out_valid clears on handshake unless a new single-cycle op is accepted in the same cycle.
- flush (priority over all):
  - next edge: out_valid=0, state=IDLE, iteration counter=0.
  - any op offered in the flush cycle is not accepted; in_ready forced 0 during flush.
- Async reset_n low, including mid-iteration: immediately out_valid=0, busy=0, out_result=0, out_zero=0, out_tag=0, state=IDLE.
- After reset release: in_ready=1.
- Iteration counter is $clog2(WIDTH)+1 bits and saturates at WIDTH.
- out_zero is registered with the result and never computed from stale data.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum with the 4-bit encodings above.
  - state enum {IDLE, ITER}.
  - helper constant OP_ITER_MASK identifying iterative opcodes.
- One sub-module, alu_muldiv_iter:
  - start/op/a/b in; done/result out.
  - shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
  - fixed WIDTH-cycle latency.
  - same clock and reset_n, and a flush input.

Test Plan:
- ADD 0x7FFFFFFF+0x1 -> 0x80000000, out_zero=0, out_valid 1 cycle after accept; SUB 5-5 -> 0, out_zero=1; legacy codes 000/001/010/110/111 match the old ALU on 1000 random vectors.
- SLT 0xFFFFFFFF,0x1 -> 1; SLTU same -> 0; SRA 0x80000000 by 4 -> 0xF8000000; SLL by in_b=0x21 -> shift 1.
- MUL 0x00010000*0x00010000 -> 0x0, zero=1; MULHU same -> 0x1; out_valid exactly 33 cycles after accept; busy=1 and in_ready=0 throughout.
- DIVU 100/7 -> 14 and REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 9/0 -> 9; tags 0xA/0xB returned in order.
- Back-pressure: out_ready low 3 cycles with ADD result held -> result/tag stable, in_ready=0. Then out_ready high with a continuous ADD stream -> one result per cycle, no drops or duplicates.
- flush asserted 10 cycles into DIVU -> out_valid never rises, in_ready=1 next cycle. reset_n pulsed low mid-MUL -> all outputs 0 asynchronously, next op completes correctly.
